// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core constants and the hazard controller state type.
package cpu_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        HZ_RUN,
        HZ_MEMWAIT
    } hz_state_t;

endpackage

// File: rtl/stall_counter.sv
// stall_counter: saturating up-counter with enable and async active-low clear.
//   clk_i  clock
//   rst_i  asynchronous active-low clear
//   en_i   count enable
//   cnt_o  count value, holds at all-ones
module stall_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            cnt_q <= '0;
        else if (en_i && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use, data-memory-wait and branch-flush control for the 5-stage pipe.
//   clk_i, rst_i (async active-low)
//   IFIDRegRS_i/IFIDRegRT_i  source registers of the instruction in ID
//   IDEXRegRT_i/IDEXMemRead_i  load destination in EX
//   Branch_i  taken branch resolved in ID
//   DCacheReq_i/DCacheAck_i  MEM-stage data-memory handshake
//   *Write_o  pipeline register write enables
//   IDEXBubble_o/MEMWBBubble_o  bubble selects, IFIDFlush_o  IF/ID clear
//   StallCnt_o  saturating count of cycles with PCWrite_o low
module hazard_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [REG_W-1:0]       IFIDRegRS_i,
    input  logic [REG_W-1:0]       IFIDRegRT_i,
    input  logic [REG_W-1:0]       IDEXRegRT_i,
    input  logic                   IDEXMemRead_i,
    input  logic                   Branch_i,
    input  logic                   DCacheReq_i,
    input  logic                   DCacheAck_i,
    output logic                   PCWrite_o,
    output logic                   IFIDWrite_o,
    output logic                   IDEXWrite_o,
    output logic                   EXMEMWrite_o,
    output logic                   IDEXBubble_o,
    output logic                   MEMWBBubble_o,
    output logic                   IFIDFlush_o,
    output logic [STALL_CNT_W-1:0] StallCnt_o
);

    hz_state_t state_q, state_d;
    logic      flush_pend_q, flush_pend_d;
    logic      memstall, loaduse;

    assign memstall = DCacheReq_i & ~DCacheAck_i;
    assign loaduse  = IDEXMemRead_i && IDEXRegRT_i != REG_ZERO &&
                      (IDEXRegRT_i == IFIDRegRS_i || IDEXRegRT_i == IFIDRegRT_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= HZ_RUN;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        // A request dropped without an ack leaves MEMWAIT just like an ack does.
        state_d = (state_q == HZ_RUN) ? (memstall ? HZ_MEMWAIT : HZ_RUN)
                                      : ((DCacheAck_i | ~DCacheReq_i) ? HZ_RUN : HZ_MEMWAIT);
        // A branch seen while frozen is remembered until the pipe moves again.
        flush_pend_d  = memstall & (flush_pend_q | Branch_i);
        PCWrite_o     = 1'b1;
        IFIDWrite_o   = 1'b1;
        IDEXWrite_o   = 1'b1;
        EXMEMWrite_o  = 1'b1;
        IDEXBubble_o  = 1'b0;
        MEMWBBubble_o = 1'b0;
        IFIDFlush_o   = 1'b0;
        if (!rst_i) begin
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IDEXWrite_o  = 1'b0;
            EXMEMWrite_o = 1'b0;
        end else if (memstall) begin
            PCWrite_o     = 1'b0;
            IFIDWrite_o   = 1'b0;
            IDEXWrite_o   = 1'b0;
            EXMEMWrite_o  = 1'b0;
            MEMWBBubble_o = 1'b1;
        end else if (flush_pend_q) begin
            // Deferred flush beats load-use: the dependent instruction is discarded anyway.
            IFIDFlush_o  = 1'b1;
            IDEXBubble_o = loaduse;
        end else if (loaduse) begin
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IDEXBubble_o = 1'b1;
        end else begin
            IFIDFlush_o = Branch_i;
        end
    end

    stall_counter #(.W(STALL_CNT_W)) u_stall_counter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (~PCWrite_o),
        .cnt_o (StallCnt_o)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed self-checking bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  IFIDRegRS_i, IFIDRegRT_i, IDEXRegRT_i;
    logic        IDEXMemRead_i, Branch_i, DCacheReq_i, DCacheAck_i;
    logic        PCWrite_o, IFIDWrite_o, IDEXWrite_o, EXMEMWrite_o;
    logic        IDEXBubble_o, MEMWBBubble_o, IFIDFlush_o;
    logic [15:0] StallCnt_o;
    logic        s_pc, s_ifid, s_idex, s_exmem, s_bub, s_mwb, s_fl;
    logic [1:0]  s_cnt;
    logic [6:0]  outs;

    int n_checks = 0;
    int n_errors = 0;

    // {PC, IFID, IDEX, EXMEM, IDEXBubble, MEMWBBubble, IFIDFlush}
    localparam logic [6:0] RUNV = 7'b1111000;
    localparam logic [6:0] LU   = 7'b0011100;
    localparam logic [6:0] MS   = 7'b0000010;
    localparam logic [6:0] FL   = 7'b1111001;
    localparam logic [6:0] FLLU = 7'b1111101;
    localparam logic [6:0] RSTV = 7'b0000000;

    always #5 clk_i = ~clk_i;

    assign outs = {PCWrite_o, IFIDWrite_o, IDEXWrite_o, EXMEMWrite_o,
                   IDEXBubble_o, MEMWBBubble_o, IFIDFlush_o};

    hazard_stall_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .IFIDRegRS_i   (IFIDRegRS_i),
        .IFIDRegRT_i   (IFIDRegRT_i),
        .IDEXRegRT_i   (IDEXRegRT_i),
        .IDEXMemRead_i (IDEXMemRead_i),
        .Branch_i      (Branch_i),
        .DCacheReq_i   (DCacheReq_i),
        .DCacheAck_i   (DCacheAck_i),
        .PCWrite_o     (PCWrite_o),
        .IFIDWrite_o   (IFIDWrite_o),
        .IDEXWrite_o   (IDEXWrite_o),
        .EXMEMWrite_o  (EXMEMWrite_o),
        .IDEXBubble_o  (IDEXBubble_o),
        .MEMWBBubble_o (MEMWBBubble_o),
        .IFIDFlush_o   (IFIDFlush_o),
        .StallCnt_o    (StallCnt_o)
    );

    hazard_stall_ctrl #(.STALL_CNT_W(2)) dut_sat (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .IFIDRegRS_i   (IFIDRegRS_i),
        .IFIDRegRT_i   (IFIDRegRT_i),
        .IDEXRegRT_i   (IDEXRegRT_i),
        .IDEXMemRead_i (IDEXMemRead_i),
        .Branch_i      (Branch_i),
        .DCacheReq_i   (DCacheReq_i),
        .DCacheAck_i   (DCacheAck_i),
        .PCWrite_o     (s_pc),
        .IFIDWrite_o   (s_ifid),
        .IDEXWrite_o   (s_idex),
        .EXMEMWrite_o  (s_exmem),
        .IDEXBubble_o  (s_bub),
        .MEMWBBubble_o (s_mwb),
        .IFIDFlush_o   (s_fl),
        .StallCnt_o    (s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] exrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic req, input logic ack);
        IDEXMemRead_i = mr;
        IDEXRegRT_i   = exrt;
        IFIDRegRS_i   = rs;
        IFIDRegRT_i   = rt;
        Branch_i      = br;
        DCacheReq_i   = req;
        DCacheAck_i   = ack;
    endtask

    // Checks the combinational outputs and the count accumulated so far, then moves to the next cycle.
    task automatic cyc(input string tag, input logic [6:0] exp, input int cnt);
        #1;
        check({tag, ".outs"}, 32'(outs), 32'(exp));
        check({tag, ".cnt"}, 32'(StallCnt_o), 32'(cnt));
        @(negedge clk_i);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset.outs", 32'(outs), 32'(RSTV));
        check("reset.cnt", 32'(StallCnt_o), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;

        drive(0, 0, 0, 0, 0, 0, 0);  cyc("idle", RUNV, 0);
        drive(1, 8, 8, 3, 0, 0, 0);  cyc("lu_rs", LU, 0);
        drive(0, 8, 8, 3, 0, 0, 0);  cyc("lu_rs_after", RUNV, 1);
        drive(1, 9, 2, 9, 0, 0, 0);  cyc("lu_rt", LU, 1);
        drive(1, 0, 0, 0, 0, 0, 0);  cyc("lu_r0", RUNV, 2);

        drive(0, 0, 0, 0, 0, 1, 0);  cyc("ms0", MS, 2);
        drive(0, 0, 0, 0, 0, 1, 0);  cyc("ms1", MS, 3);
        drive(0, 0, 0, 0, 0, 1, 0);  cyc("ms2", MS, 4);
        drive(0, 0, 0, 0, 0, 1, 1);  cyc("ms_ack", RUNV, 5);

        drive(0, 0, 0, 0, 0, 1, 0);  cyc("br_ms0", MS, 5);
        drive(0, 0, 0, 0, 1, 1, 0);  cyc("br_ms1", MS, 6);
        drive(0, 0, 0, 0, 0, 1, 0);  cyc("br_ms2", MS, 7);
        drive(0, 0, 0, 0, 0, 1, 1);  cyc("br_ack", FL, 8);
        drive(0, 0, 0, 0, 0, 0, 0);  cyc("br_after", RUNV, 8);

        drive(0, 0, 0, 0, 1, 0, 0);  cyc("br_plain", FL, 8);
        drive(1, 7, 7, 0, 1, 0, 0);  cyc("br_lu", LU, 8);
        drive(0, 0, 0, 0, 0, 0, 0);  cyc("br_lu_after", RUNV, 9);

        drive(1, 4, 0, 4, 0, 1, 0);  cyc("mslu0", MS, 9);
        drive(1, 4, 0, 4, 0, 1, 0);  cyc("mslu1", MS, 10);
        drive(1, 4, 0, 4, 0, 1, 1);  cyc("mslu_ack", LU, 11);
        drive(0, 4, 0, 4, 0, 0, 0);  cyc("mslu_after", RUNV, 12);

        drive(0, 0, 0, 0, 1, 1, 0);  cyc("pend_ms", MS, 12);
        drive(1, 6, 6, 0, 0, 1, 1);  cyc("pend_lu", FLLU, 13);
        drive(0, 0, 0, 0, 0, 0, 0);  cyc("pend_after", RUNV, 13);

        drive(0, 0, 0, 0, 0, 1, 1);  cyc("zw0", RUNV, 13);
        drive(0, 0, 0, 0, 0, 1, 1);  cyc("zw1", RUNV, 13);

        drive(0, 0, 0, 0, 0, 1, 0);  cyc("proto_ms", MS, 13);
        drive(0, 0, 0, 0, 0, 0, 0);  cyc("proto_drop", RUNV, 14);

        drive(0, 0, 0, 0, 1, 1, 0);
        #1;
        check("rst_pre.outs", 32'(outs), 32'(MS));
        @(posedge clk_i);
        #1;
        check("rst_pre.cnt", 32'(StallCnt_o), 15);
        #1;
        rst_i = 1'b0;
        #1;
        check("rst_mid.outs", 32'(outs), 32'(RSTV));
        check("rst_mid.cnt", 32'(StallCnt_o), 0);
        check("rst_mid.sat", 32'(s_cnt), 0);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 1, 0);
        #1;
        check("rst_hold.outs", 32'(outs), 32'(RSTV));
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);  cyc("rst_release", RUNV, 0);

        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            #1;
            check("sat.sat", 32'(s_cnt), (i > 3) ? 3 : i);
            cyc("sat", MS, i);
        end
        drive(0, 0, 0, 0, 0, 1, 1);
        #1;
        check("sat_end.sat", 32'(s_cnt), 3);
        cyc("sat_end", RUNV, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
